simon_pattern_player: RTL
=========================

Name: simon_pattern_player

Overview:
- Downstream consumer of the simple tick counter in the Simon Says game.
- Each change of the counter's toggle output is one game-time tick.
- On a start request, the block replays the current level's LED pattern on the four board LEDs. The pattern is a pseudo-random sequence regenerated from a seed, so every replay of a level shows the same elements.
- It signals completion so the game controller can hand over to the button-input checker.

Parameters:
- ON_TICKS, 2, ticks an LED stays lit per element (≥1).
- OFF_TICKS, 1, ticks of dark gap after each element (≥1).
- MAX_LEVEL, 15, maximum pattern length.
- LEVEL_W, $clog2(MAX_LEVEL+1), width of the level input.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  synchronous active-high reset.
- i_Toggle  in  1  toggle output of the upstream counter; each edge is one tick.
- i_Start  in  1  one-cycle request to play the pattern.
- i_Level  in  LEVEL_W  number of elements to play, sampled with i_Start.
- i_Seed  in  16  LFSR seed, sampled with i_Start.
- o_LED  out  4  one-hot lit LED, 0 when dark.
- o_Index  out  2  index of the element currently shown.
- o_IndexValid  out  1  one-cycle pulse on entry to each ON phase.
- o_Busy  out  1  high from the cycle after an accepted i_Start until o_Done.
- o_Done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Clock and reset:
  - One clock, i_Clk.
  - Reset is synchronous and active-high (i_Rst).
  - On reset: state=IDLE; o_LED=0; o_Index=0; o_IndexValid=0; o_Busy=0; o_Done=0; tick counter=0; element counter=0; LFSR=16'hACE1; toggle delay register loaded with i_Toggle.
  - Reset asserted mid-playback aborts playback at the next edge: LEDs dark, no o_Done pulse.
- Tick detection:
  - tick = i_Toggle XOR i_Toggle delayed by one cycle.
  - Both edges count as ticks.
  - The delay register tracks i_Toggle in every state.
  - Ticks are ignored outside ON and OFF.
- IDLE:
  - i_Start=1 latches i_Level and i_Seed, then goes to LOAD.
  - A seed of 0 is replaced by 16'hACE1.
  - i_Level values above MAX_LEVEL are clamped to MAX_LEVEL.
  - i_Start is ignored in every other state.
- LOAD (1 cycle):
  - o_Busy=1; element counter=0; tick counter=0.
  - If latched level=0, go to DONE.
  - Otherwise go to ON.
- ON:
  - On entry, o_Index=LFSR[1:0], o_LED=one-hot of o_Index, and o_IndexValid pulses for that entry cycle.
  - Each tick increments the tick counter.
  - On the tick that makes it ON_TICKS: go to OFF, o_LED=0 on the same edge, tick counter cleared.
- OFF:
  - Each tick increments the tick counter.
  - On the tick that makes it OFF_TICKS:
    - If element counter+1 = level, go to DONE.
    - Otherwise increment the element counter, step the LFSR once, clear the tick counter and go to ON.
- LFSR:
  - 16-bit Fibonacci, right shift.
  - fb = b0^b2^b3^b5; next = {fb, lfsr[15:1]}.
  - Element k uses the state after k steps from the seed.
- DONE (1 cycle):
  - o_Done=1, o_Busy=0 and o_LED=0 at the cycle state enters DONE.
  - Then IDLE.
- Latency:
  - i_Start at edge N gives LOAD at N+1 and first LED at N+2.
  - Total playback = level × (ON_TICKS+OFF_TICKS) ticks, plus 2 cycles.
- Counters never wrap:
  - Tick counter width is $clog2(max(ON_TICKS,OFF_TICKS)+1).
  - Element counter width is LEVEL_W.

Test Plan:
- Reset: toggle i_Toggle with i_Rst=1 → all outputs 0, state IDLE, no o_IndexValid.
- Basic play: ON_TICKS=2, OFF_TICKS=1, i_Level=3, i_Seed=16'hACE1, ticks every 10 cycles → o_LED sequence 4'b0010, 4'b0001, 4'b0001, each lit exactly 2 ticks with a 1-tick dark gap; o_Done pulses once; o_Busy falls with o_Done.
- Replay determinism: repeat the same start twice → identical o_Index sequence; i_Seed=0 → same as seed 16'hACE1.
- Level 0 and clamp: i_Level=0 → o_Done 2 cycles after i_Start, o_LED never set; i_Level=MAX_LEVEL+1 (if representable) → exactly MAX_LEVEL o_IndexValid pulses.
- Start while busy and idle ticks: pulse i_Start mid-playback with a different seed → ignored, sequence unchanged; ticks while IDLE → no output change.
- Reset mid-operation: assert i_Rst during the second ON phase → o_LED=0 next edge, no o_Done; subsequent i_Start plays the full pattern from element 0.

Source files
------------

// File: rtl/simon_pattern_player.sv
// Simon Says pattern player: replays the current level's LED pattern,
// one element per ON/OFF tick window, from a seeded LFSR.
module simon_pattern_player #(
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1,
    parameter int MAX_LEVEL = 15,
    parameter int LEVEL_W   = $clog2(MAX_LEVEL + 1)
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Toggle,
    input  logic               i_Start,
    input  logic [LEVEL_W-1:0] i_Level,
    input  logic [15:0]        i_Seed,
    output logic [3:0]         o_LED,
    output logic [1:0]         o_Index,
    output logic               o_IndexValid,
    output logic               o_Busy,
    output logic               o_Done
);

    localparam int MAX_T  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W = $clog2(MAX_T + 1);

    localparam logic [TICK_W-1:0]  ON_T     = TICK_W'(ON_TICKS);
    localparam logic [TICK_W-1:0]  OFF_T    = TICK_W'(OFF_TICKS);
    localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);
    localparam logic [15:0]        SEED_DEF = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic                tgl_q;
    logic                tick;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt, tick_inc;
    logic [LEVEL_W-1:0]  elem_cnt, elem_nxt, elem_inc;
    logic [LEVEL_W-1:0]  level_q, level_nxt, level_in;
    logic [15:0]         lfsr, lfsr_nxt;
    logic [3:0]          led_nxt;
    logic [1:0]          idx_nxt;
    logic                iv_nxt, busy_nxt, done_nxt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    assign tick     = i_Toggle ^ tgl_q;
    assign tick_inc = tick_cnt + 1'b1;
    assign elem_inc = elem_cnt + 1'b1;
    // Widened compare keeps the clamp meaningful for any MAX_LEVEL/width mix
    assign level_in = ({1'b0, i_Level} > {1'b0, MAX_L}) ? MAX_L : i_Level;

    // State register and all registered outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= S_IDLE;
            tgl_q        <= i_Toggle;
            tick_cnt     <= '0;
            elem_cnt     <= '0;
            level_q      <= '0;
            lfsr         <= SEED_DEF;
            o_LED        <= '0;
            o_Index      <= '0;
            o_IndexValid <= 1'b0;
            o_Busy       <= 1'b0;
            o_Done       <= 1'b0;
        end else begin
            state        <= state_nxt;
            tgl_q        <= i_Toggle;
            tick_cnt     <= tick_nxt;
            elem_cnt     <= elem_nxt;
            level_q      <= level_nxt;
            lfsr         <= lfsr_nxt;
            o_LED        <= led_nxt;
            o_Index      <= idx_nxt;
            o_IndexValid <= iv_nxt;
            o_Busy       <= busy_nxt;
            o_Done       <= done_nxt;
        end
    end

    // Next-state logic; outputs derive from the state being entered
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        elem_nxt  = elem_cnt;
        level_nxt = level_q;
        lfsr_nxt  = lfsr;

        unique case (state)
            S_IDLE: begin
                if (i_Start) begin
                    level_nxt = level_in;
                    lfsr_nxt  = (i_Seed == 16'h0) ? SEED_DEF : i_Seed;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                elem_nxt  = '0;
                tick_nxt  = '0;
                state_nxt = (level_q == '0) ? S_DONE : S_ON;
            end
            S_ON: begin
                if (tick) begin
                    if (tick_inc == ON_T) begin
                        tick_nxt  = '0;
                        state_nxt = S_OFF;
                    end else begin
                        tick_nxt = tick_inc;
                    end
                end
            end
            S_OFF: begin
                if (tick) begin
                    if (tick_inc == OFF_T) begin
                        if (elem_inc == level_q) begin
                            state_nxt = S_DONE;
                        end else begin
                            elem_nxt  = elem_inc;
                            lfsr_nxt  = lfsr_step(lfsr);
                            tick_nxt  = '0;
                            state_nxt = S_ON;
                        end
                    end else begin
                        tick_nxt = tick_inc;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        led_nxt  = '0;
        idx_nxt  = o_Index;
        iv_nxt   = 1'b0;
        busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_ON) ||
                   (state_nxt == S_OFF);
        done_nxt = (state_nxt == S_DONE);

        if (state_nxt == S_ON) begin
            if (state != S_ON) begin
                idx_nxt = lfsr_nxt[1:0];
                iv_nxt  = 1'b1;
            end
            led_nxt = 4'b0001 << idx_nxt;
        end
    end

endmodule
